// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants and types for the memory/peripheral port arbiter.
// Decode bit, strobe levels and the zero word live here so all users agree.
package mem_port_arbiter_pkg;

  localparam int          DEC_BIT    = 30;
  localparam logic        STROBE_ON  = 1'b1;
  localparam logic        STROBE_OFF = 1'b0;
  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

  typedef enum logic {
    IDLE     = 1'b0,
    PER_BUSY = 1'b1
  } state_t;

  typedef enum logic {
    OWN_M0 = 1'b0,
    OWN_M1 = 1'b1
  } owner_t;

  function automatic logic is_periph(input logic [31:0] addr);
    return addr[DEC_BIT];
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for the shared data-memory / peripheral bus.
// Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed m0 priority.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int PER_WAIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_re,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_stall,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        mem_re,
  output logic        mem_we,
  output logic        per_re,
  output logic        per_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] mem_rdata,
  input  logic [31:0] per_rdata
);

  state_t      state;
  owner_t      owner;
  logic [3:0]  cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  logic        m0_act, m1_act, grant_m0, grant_m1;
  logic        sel_m1, valid, sel_rd, sel_wr, sel_per, complete;
  logic [31:0] sel_addr, sel_wdata, rd_word;

  // m1 is masked during its ack cycle so a held request is not granted twice.
  always_comb begin
    m0_act = m0_re | m0_we;
    m1_act = m1_req & ~m1_ack;
`ifdef ARB_ROUND_ROBIN_EN
    if (m0_act && m1_act) begin
      grant_m0 = last_grant;
      grant_m1 = ~last_grant;
    end else begin
      grant_m0 = m0_act;
      grant_m1 = m1_act;
    end
`else
    grant_m0 = m0_act;
    grant_m1 = m1_act & ~m0_act;
`endif
    if (state == PER_BUSY) begin
      sel_m1 = (owner == OWN_M1);
      valid  = rst;
    end else begin
      sel_m1 = grant_m1;
      valid  = rst & (grant_m0 | grant_m1);
    end
    sel_wr    = sel_m1 ? m1_we : m0_we;
    sel_rd    = sel_m1 ? ~m1_we : (m0_re & ~m0_we);
    sel_addr  = sel_m1 ? m1_addr : m0_addr;
    sel_wdata = sel_m1 ? m1_wdata : m0_wdata;
    sel_per   = is_periph(sel_addr);
    rd_word   = sel_per ? per_rdata : mem_rdata;
    if (state == PER_BUSY)
      complete = valid & (cnt == 4'd1);
    else
      complete = valid & (~sel_per | (PER_WAIT == 1));
  end

  assign mem_re    = (valid & ~sel_per & sel_rd) ? STROBE_ON : STROBE_OFF;
  assign mem_we    = (valid & ~sel_per & sel_wr) ? STROBE_ON : STROBE_OFF;
  assign per_re    = (valid &  sel_per & sel_rd) ? STROBE_ON : STROBE_OFF;
  assign per_we    = (valid &  sel_per & sel_wr) ? STROBE_ON : STROBE_OFF;
  assign bus_addr  = valid ? sel_addr : ZERO_WORD;
  assign bus_wdata = (valid & sel_wr) ? sel_wdata : ZERO_WORD;
  assign m0_rdata  = (complete & ~sel_m1 & sel_rd) ? rd_word : ZERO_WORD;
  assign m0_stall  = rst & m0_act & ~(complete & ~sel_m1);

  // Busy countdown, owner latch and m1 completion registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      owner    <= OWN_M0;
      cnt      <= 4'd0;
      m1_ack   <= 1'b0;
      m1_rdata <= ZERO_WORD;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b0;
`endif
    end else begin
      m1_ack <= complete & sel_m1;
      if (complete && sel_m1)
        m1_rdata <= sel_rd ? rd_word : ZERO_WORD;
      case (state)
        IDLE: begin
          if (valid && sel_per && !complete) begin
            state <= PER_BUSY;
            cnt   <= 4'(PER_WAIT - 1);
            owner <= sel_m1 ? OWN_M1 : OWN_M0;
          end
`ifdef ARB_ROUND_ROBIN_EN
          if (valid)
            last_grant <= sel_m1;
`endif
        end
        PER_BUSY: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
